lvds_rx_arbiter: RTL and testbench

//  Merges the two lvds_rx sample streams (sub-GHz and 2.4 GHz receivers) into the single SMI read FIFO.

---
 rtl/lvds_rx_arbiter_pkg.sv | 13 +
 rtl/lvds_rx_arbiter_if.sv | 54 +++++
 rtl/lvds_rx_elastic_buf.sv | 53 +++++
 rtl/lvds_rx_arbiter.sv | 119 +++++++++++
 tb/tb_lvds_rx_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_rx_arbiter_pkg.sv
// Shared channel and word definitions for the lvds_rx merge path.
// Used by the arbiter, its buffers and its bus interface.
package lvds_rx_arbiter_pkg;

  localparam int CH_09  = 0;
  localparam int CH_24  = 1;
  localparam int NUM_CH = 2;
  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

endpackage

// File: rtl/lvds_rx_arbiter_if.sv
// Bus bundle between the two lvds_rx streams, the SMI FIFO port
// and the arbiter; master drives inputs, slave is the arbiter.
interface lvds_rx_arbiter_if #(
  parameter int CNT_W = 16
);
  import lvds_rx_arbiter_pkg::*;

  ch_mask_t         i_ch_en;
  logic             i_ch0_push;
  word_t            i_ch0_data;
  logic             i_ch1_push;
  word_t            i_ch1_data;
  logic             i_fifo_full;
  logic             o_fifo_push;
  word_t            o_fifo_data;
  logic             o_fifo_chan;
  logic             i_clear_stats;
  logic [CNT_W-1:0] o_ch0_drops;
  logic [CNT_W-1:0] o_ch1_drops;
  ch_mask_t         o_overflow;

  modport master (
    output i_ch_en,
    output i_ch0_push,
    output i_ch0_data,
    output i_ch1_push,
    output i_ch1_data,
    output i_fifo_full,
    output i_clear_stats,
    input  o_fifo_push,
    input  o_fifo_data,
    input  o_fifo_chan,
    input  o_ch0_drops,
    input  o_ch1_drops,
    input  o_overflow
  );

  modport slave (
    input  i_ch_en,
    input  i_ch0_push,
    input  i_ch0_data,
    input  i_ch1_push,
    input  i_ch1_data,
    input  i_fifo_full,
    input  i_clear_stats,
    output o_fifo_push,
    output o_fifo_data,
    output o_fifo_chan,
    output o_ch0_drops,
    output o_ch1_drops,
    output o_overflow
  );

endinterface

// File: rtl/lvds_rx_elastic_buf.sv
// Per-channel elastic FIFO; a write while full succeeds only
// when a read retires an entry on the same edge.
module lvds_rx_elastic_buf
  import lvds_rx_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr,
  input  word_t wr_data,
  input  logic  rd,
  output word_t rd_data,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_rd;
  logic          do_wr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_rd   = rd & ~empty;
  assign do_wr   = wr & (~full | do_rd);
  assign rd_data = mem[rp];

  always_ff @(negedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/lvds_rx_arbiter.sv
// Round-robin merge of two lvds_rx streams into the SMI FIFO,
// with per-channel enables, saturating drop counters and flags.
module lvds_rx_arbiter
  import lvds_rx_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input logic               i_ddr_clk,
  input logic               i_reset,
  lvds_rx_arbiter_if.slave  bus
);

  word_t    din     [NUM_CH];
  word_t    rd_data [NUM_CH];
  ch_mask_t push;
  ch_mask_t acc;
  ch_mask_t empty;
  ch_mask_t full;
  ch_mask_t avail;
  ch_mask_t pop;
  ch_mask_t wr;
  ch_mask_t rd;
  ch_mask_t drop;
  logic     any;
  logic     grant;
  logic     rr_ptr;
  word_t    pick;

  logic             push_q;
  word_t            data_q;
  logic             chan_q;
  logic [CNT_W-1:0] drops_q [NUM_CH];
  ch_mask_t         ovf_q;

  assign din[CH_09] = bus.i_ch0_data;
  assign din[CH_24] = bus.i_ch1_data;
  assign push       = {bus.i_ch1_push, bus.i_ch0_push};
  assign acc        = push & bus.i_ch_en;

  // An empty buffer forwards its incoming word straight to the pop mux
  assign avail = ~empty | acc;
  assign any   = ~bus.i_fifo_full & (|avail);

  always_comb begin
    grant = rr_ptr;
    unique case (avail)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = rr_ptr;
    endcase
  end

  assign pop  = {any & grant, any & ~grant};
  assign rd   = pop & ~empty;
  assign wr   = acc & ~(pop & empty);
  assign drop = acc & full & ~pop;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_buf
    lvds_rx_elastic_buf #(
      .DEPTH(BUF_DEPTH)
    ) u_buf (
      .clk    (i_ddr_clk),
      .rst    (i_reset),
      .wr     (wr[k]),
      .wr_data(din[k]),
      .rd     (rd[k]),
      .rd_data(rd_data[k]),
      .full   (full[k]),
      .empty  (empty[k])
    );
  end

  always_comb begin
    if (empty[grant]) pick = din[grant];
    else              pick = rd_data[grant];
  end

  always_ff @(negedge i_ddr_clk or posedge i_reset) begin
    if (i_reset) begin
      push_q <= 1'b0;
      data_q <= '0;
      chan_q <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      push_q <= any;
      if (any) begin
        data_q <= pick;
        chan_q <= grant;
        rr_ptr <= ~grant;
      end
    end
  end

  // Clear takes priority over a drop landing on the same edge
  always_ff @(negedge i_ddr_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_CH; k++) drops_q[k] <= '0;
      ovf_q <= '0;
    end else if (bus.i_clear_stats) begin
      for (int k = 0; k < NUM_CH; k++) drops_q[k] <= '0;
      ovf_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (drop[k] && drops_q[k] != '1)
          drops_q[k] <= drops_q[k] + CNT_W'(1);
      end
      ovf_q <= ovf_q | drop;
    end
  end

  assign bus.o_fifo_push = push_q;
  assign bus.o_fifo_data = data_q;
  assign bus.o_fifo_chan = chan_q;
  assign bus.o_ch0_drops = drops_q[CH_09];
  assign bus.o_ch1_drops = drops_q[CH_24];
  assign bus.o_overflow  = ovf_q;

endmodule

// File: tb/tb_lvds_rx_arbiter.sv
// Directed bench for lvds_rx_arbiter: streaming, alternation,
// backpressure, saturation, enables and reset discard.
module tb_lvds_rx_arbiter;
  import lvds_rx_arbiter_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvds_rx_arbiter_if #(.CNT_W(CNT_W)) bus ();

  lvds_rx_arbiter #(
    .BUF_DEPTH(4),
    .CNT_W    (CNT_W)
  ) dut (
    .i_ddr_clk(clk),
    .i_reset  (rst),
    .bus      (bus.slave)
  );

  int    n_pass = 0;
  int    n_chk  = 0;
  int    cyc    = 0;
  word_t cap_d [$];
  logic  cap_c [$];
  int    cap_t [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_fifo_push) begin
      cap_d.push_back(bus.o_fifo_data);
      cap_c.push_back(bus.o_fifo_chan);
      cap_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_ch0_push    = 1'b0;
    bus.i_ch1_push    = 1'b0;
    bus.i_clear_stats = 1'b0;
  endtask

  task automatic clr_cap();
    cap_d.delete();
    cap_c.delete();
    cap_t.delete();
  endtask

  task automatic do_reset();
    idle();
    bus.i_fifo_full = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clr_cap();
  endtask

  word_t t2_d [6];
  logic  t2_c [6];

  initial begin
    bus.i_ch_en       = 2'b00;
    bus.i_ch0_data    = '0;
    bus.i_ch1_data    = '0;
    bus.i_fifo_full   = 1'b0;
    idle();
    t2_d = '{32'hA10, 32'hB20, 32'hA11,
             32'hB21, 32'hA12, 32'hB22};
    t2_c = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // 1: single channel stream, one-cycle latency
    do_reset();
    chk("rst push", bus.o_fifo_push, 0);
    chk("rst data", bus.o_fifo_data, 0);
    chk("rst chan", bus.o_fifo_chan, 0);
    chk("rst drop0", bus.o_ch0_drops, 0);
    chk("rst drop1", bus.o_ch1_drops, 0);
    chk("rst ovf", bus.o_overflow, 0);
    bus.i_ch_en = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.i_ch0_push = 1'b1;
      bus.i_ch0_data = 32'hA000_0000 + i;
      tick();
      bus.i_ch0_push = 1'b0;
      chk("t1 push", bus.o_fifo_push, 1);
      chk("t1 data", bus.o_fifo_data,
          32'hA000_0000 + i);
      chk("t1 chan", bus.o_fifo_chan, 0);
      tick();
      chk("t1 strobe", bus.o_fifo_push, 0);
      repeat (14) tick();
    end
    chk("t1 count", cap_d.size(), 4);
    chk("t1 drops", bus.o_ch0_drops, 0);

    // 2: coincident pushes alternate back to back
    do_reset();
    bus.i_ch_en = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.i_ch0_push = 1'b1;
      bus.i_ch1_push = 1'b1;
      bus.i_ch0_data = 32'hA10 + i;
      bus.i_ch1_data = 32'hB20 + i;
      tick();
    end
    idle();
    repeat (5) tick();
    chk("t2 count", cap_d.size(), 6);
    for (int j = 0; j < 6; j++) begin
      if (j < cap_d.size()) begin
        chk("t2 data", cap_d[j], t2_d[j]);
        chk("t2 chan", cap_c[j], t2_c[j]);
        chk("t2 b2b", cap_t[j] - cap_t[0], j);
      end
    end

    // 3: backpressure fills the buffer, overflow drops two
    do_reset();
    bus.i_ch_en = 2'b01;
    bus.i_fifo_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.i_ch0_push = 1'b1;
      bus.i_ch0_data = 32'hC0 + i;
      tick();
    end
    idle();
    tick();
    chk("t3 held", cap_d.size(), 0);
    chk("t3 drops0", bus.o_ch0_drops, 2);
    chk("t3 drops1", bus.o_ch1_drops, 0);
    chk("t3 ovf", bus.o_overflow, 2'b01);
    bus.i_fifo_full = 1'b0;
    repeat (8) tick();
    chk("t3 count", cap_d.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < cap_d.size()) begin
        chk("t3 data", cap_d[j], 32'hC0 + j);
        chk("t3 chan", cap_c[j], 0);
      end
    end
    chk("t3 drops0 kept", bus.o_ch0_drops, 2);

    // 4: drop counter saturation and clear priority
    do_reset();
    bus.i_ch_en = 2'b10;
    bus.i_fifo_full = 1'b1;
    bus.i_ch1_push = 1'b1;
    bus.i_ch1_data = 32'hD00D;
    repeat (4 + 65534) tick();
    chk("t4 preload", bus.o_ch1_drops, 16'hFFFE);
    chk("t4 ovf", bus.o_overflow, 2'b10);
    tick();
    chk("t4 sat", bus.o_ch1_drops, 16'hFFFF);
    repeat (2) tick();
    chk("t4 sat hold", bus.o_ch1_drops, 16'hFFFF);
    chk("t4 drops0", bus.o_ch0_drops, 0);
    bus.i_clear_stats = 1'b1;
    tick();
    bus.i_clear_stats = 1'b0;
    chk("t4 clr cnt", bus.o_ch1_drops, 0);
    chk("t4 clr ovf", bus.o_overflow, 0);
    tick();
    bus.i_ch1_push = 1'b0;
    chk("t4 recount", bus.o_ch1_drops, 1);
    chk("t4 reflag", bus.o_overflow, 2'b10);

    // 5: disabled channel ignored, buffered words drain
    do_reset();
    bus.i_ch_en = 2'b10;
    for (int i = 0; i < 2; i++) begin
      bus.i_ch0_push = 1'b1;
      bus.i_ch0_data = 32'hE0 + i;
      tick();
    end
    idle();
    tick();
    chk("t5 ignored", cap_d.size(), 0);
    chk("t5 drops0", bus.o_ch0_drops, 0);
    chk("t5 ovf", bus.o_overflow, 0);
    bus.i_fifo_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.i_ch1_push = 1'b1;
      bus.i_ch1_data = 32'hF0 + i;
      tick();
    end
    idle();
    bus.i_ch_en = 2'b00;
    tick();
    bus.i_fifo_full = 1'b0;
    repeat (4) tick();
    chk("t5 count", cap_d.size(), 2);
    for (int j = 0; j < 2; j++) begin
      if (j < cap_d.size()) begin
        chk("t5 data", cap_d[j], 32'hF0 + j);
        chk("t5 chan", cap_c[j], 1);
      end
    end

    // 6: reset mid-transfer discards buffered words
    do_reset();
    bus.i_ch_en = 2'b11;
    for (int i = 0; i < 3; i++) begin
      bus.i_ch0_push = 1'b1;
      bus.i_ch1_push = 1'b1;
      bus.i_ch0_data = 32'h5A0 + i;
      bus.i_ch1_data = 32'h5B0 + i;
      tick();
    end
    idle();
    chk("t6 busy", bus.o_fifo_push, 1);
    rst = 1'b1;
    #1;
    chk("t6 rst push", bus.o_fifo_push, 0);
    chk("t6 rst data", bus.o_fifo_data, 0);
    chk("t6 rst chan", bus.o_fifo_chan, 0);
    tick();
    clr_cap();
    rst = 1'b0;
    repeat (8) tick();
    chk("t6 no stale", cap_d.size(), 0);
    chk("t6 data", bus.o_fifo_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
